// File: rtl/chimera_pkg.sv
// Shared types and constants for the Chimera cluster power controller.
// Build option: CHIMERA_PWR_TIMEOUT_EN enables forced gating after a drain timeout.
package chimera_pkg;

  // Number of external clusters in the default Chimera configuration.
  localparam int unsigned ExtClusters = 5;

  // Per-cluster power state; the encoding is what STATUS reports.
  typedef enum logic [1:0] {
    PWR_OFF   = 2'd0,
    PWR_WAKE  = 2'd1,
    PWR_RUN   = 2'd2,
    PWR_DRAIN = 2'd3
  } pwr_state_e;

  // Register byte offsets within the region.
  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_STATUS   = 8'h04;
  localparam logic [7:0] OFS_IRQ_PEND = 8'h08;
  localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFS_TIMEOUT  = 8'h10;

  // Width needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chimera_cluster_pwr_fsm.sv
// Power sequencer for one cluster: OFF -> WAKE -> RUN -> DRAIN -> OFF.
// Build option: CHIMERA_PWR_TIMEOUT_EN bounds the DRAIN wait to TimeoutCyc cycles.
module chimera_cluster_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned RstCycles  = 8,
  parameter int unsigned TimeoutCyc = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       target_i,
  input  logic       busy_i,
  output pwr_state_e state_o,
  output logic       clk_en_o,
  output logic       rst_o,
  output logic       iso_o,
`ifdef CHIMERA_PWR_TIMEOUT_EN
  output logic       timeout_o,
`endif
  output logic       done_o
);

  localparam int unsigned CntMax = (RstCycles > TimeoutCyc) ? RstCycles : TimeoutCyc;
  localparam int unsigned CntW   = cnt_width(CntMax);
  localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles);
`ifdef CHIMERA_PWR_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLoad = CntW'(TimeoutCyc);
`endif

  pwr_state_e      state, state_d;
  logic [CntW-1:0] cnt, cnt_d;
  logic            done_d;
  logic            tmo_d;

  // Next-state and counter logic. The counter is only decremented while it
  // is above one and the sequence ends at one, so it never wraps below zero.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state)
      PWR_OFF: begin
        if (target_i) begin
          state_d = PWR_WAKE;
          cnt_d   = RstLoad;
        end
      end
      PWR_WAKE: begin
        // Target changes are ignored here; the wake sequence always completes.
        if (cnt <= CntW'(1)) begin
          state_d = PWR_RUN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CntW'(1);
        end
      end
      PWR_RUN: begin
        if (!target_i) begin
          state_d = PWR_DRAIN;
`ifdef CHIMERA_PWR_TIMEOUT_EN
          cnt_d   = TmoLoad;
`endif
        end
      end
      PWR_DRAIN: begin
        if (!busy_i) begin
          state_d = PWR_OFF;
          cnt_d   = '0;
          done_d  = 1'b1;
`ifdef CHIMERA_PWR_TIMEOUT_EN
        end else if (cnt <= CntW'(1)) begin
          // Traffic never drained: gate anyway and flag it.
          state_d = PWR_OFF;
          cnt_d   = '0;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt - CntW'(1);
`endif
        end
      end
      default: begin
        state_d = PWR_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= PWR_OFF;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Gating controls decode straight from the state so reset and clock
  // disable move on the same edge that enters OFF.
  always_comb begin
    clk_en_o = (state != PWR_OFF);
    rst_o    = (state == PWR_OFF) || (state == PWR_WAKE);
    iso_o    = (state != PWR_RUN);
  end

  assign state_o = state;
  assign done_o  = done_d;
`ifdef CHIMERA_PWR_TIMEOUT_EN
  assign timeout_o = tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = tmo_d;
`endif

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// Register-mapped clock-gate / reset sequencer for NumClusters clusters.
// Regs: CTRL (targets), STATUS (states), IRQ_PEND (W1C), IRQ_EN, and
// TIMEOUT (W1C) when built with CHIMERA_PWR_TIMEOUT_EN.
module chimera_cluster_pwr_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters = ExtClusters,
  parameter int unsigned RstCycles   = 8,
  parameter int unsigned TimeoutCyc  = 256,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  output logic                   reg_ready_o,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  input  logic [NumClusters-1:0] busy_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] rst_o,
  output logic [NumClusters-1:0] isolate_o,
  output logic                   irq_o
);

  logic [NumClusters-1:0]   ctrl;
  logic [NumClusters-1:0]   irq_pend;
  logic [NumClusters-1:0]   irq_en;
  logic [NumClusters-1:0]   done;
  logic [2*NumClusters-1:0] status_vec;
  pwr_state_e               st [NumClusters];

`ifdef CHIMERA_PWR_TIMEOUT_EN
  logic [NumClusters-1:0]   tmo_flag;
  logic [NumClusters-1:0]   tmo_hit;
`endif

  logic                   req;
  logic                   hit_ctrl, hit_status, hit_pend, hit_en, hit_tmo;
  logic                   acc_err;
  logic                   we;
  logic [NumClusters-1:0] wmask;
  logic [DataWidth-1:0]   rdata_d;

  // A new access is one not already being answered this cycle.
  assign req   = reg_valid_i & ~reg_ready_o;
  assign wmask = reg_wdata_i[NumClusters-1:0];

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i[DataWidth-1:NumClusters];

  // Address decode. Exact matches against word offsets also reject
  // misaligned addresses, since those never equal a register offset.
  always_comb begin
    hit_ctrl   = (reg_addr_i == AddrWidth'(OFS_CTRL));
    hit_status = (reg_addr_i == AddrWidth'(OFS_STATUS));
    hit_pend   = (reg_addr_i == AddrWidth'(OFS_IRQ_PEND));
    hit_en     = (reg_addr_i == AddrWidth'(OFS_IRQ_EN));
`ifdef CHIMERA_PWR_TIMEOUT_EN
    hit_tmo    = (reg_addr_i == AddrWidth'(OFS_TIMEOUT));
`else
    hit_tmo    = 1'b0;
`endif
    acc_err = !(hit_ctrl || hit_status || hit_pend || hit_en || hit_tmo)
              || (reg_write_i && hit_status);
    we      = req && reg_write_i && !acc_err;
  end

  // Read data mux; unimplemented high bits read as zero.
  always_comb begin
    rdata_d = '0;
    if (hit_ctrl)        rdata_d = DataWidth'(ctrl);
    else if (hit_status) rdata_d = DataWidth'(status_vec);
    else if (hit_pend)   rdata_d = DataWidth'(irq_pend);
    else if (hit_en)     rdata_d = DataWidth'(irq_en);
`ifdef CHIMERA_PWR_TIMEOUT_EN
    else if (hit_tmo)    rdata_d = DataWidth'(tmo_flag);
`endif
  end

  // Handshake: answer one cycle after the request is seen, for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_ready_o <= 1'b0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
    end else begin
      reg_ready_o <= req;
      if (req) begin
        reg_rdata_o <= acc_err ? '0 : rdata_d;
        reg_error_o <= acc_err;
      end
    end
  end

  // CTRL and IRQ_EN plain RW registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl   <= '0;
      irq_en <= '0;
    end else begin
      if (we && hit_ctrl) ctrl   <= wmask;
      if (we && hit_en)   irq_en <= wmask;
    end
  end

  // IRQ_PEND: write-one-to-clear, a completion on the same edge wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_pend <= '0;
    end else begin
      irq_pend <= (irq_pend & ~((we && hit_pend) ? wmask : '0)) | done;
    end
  end

`ifdef CHIMERA_PWR_TIMEOUT_EN
  // TIMEOUT: sticky forced-gating flags, write-one-to-clear, set wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_flag <= '0;
    end else begin
      tmo_flag <= (tmo_flag & ~((we && hit_tmo) ? wmask : '0)) | tmo_hit;
    end
  end
`endif

  assign irq_o = |(irq_pend & irq_en);

  for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
    chimera_cluster_pwr_fsm #(
      .RstCycles  (RstCycles),
      .TimeoutCyc (TimeoutCyc)
    ) u_fsm (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .target_i  (ctrl[g]),
      .busy_i    (busy_i[g]),
      .state_o   (st[g]),
      .clk_en_o  (clk_en_o[g]),
      .rst_o     (rst_o[g]),
      .iso_o     (isolate_o[g]),
`ifdef CHIMERA_PWR_TIMEOUT_EN
      .timeout_o (tmo_hit[g]),
`endif
      .done_o    (done[g])
    );
    assign status_vec[2*g +: 2] = st[g];
  end

endmodule

// File: tb/tb_chimera_cluster_pwr_ctrl.sv
// Bench for chimera_cluster_pwr_ctrl: directed steps then random traffic,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_chimera_cluster_pwr_ctrl;

  localparam int N   = 5;
  localparam int RST = 8;
  localparam int TMO = 256;
`ifdef CHIMERA_PWR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] MASK = 32'h1F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_valid = 1'b0;
  logic          reg_ready;
  logic          reg_write = 1'b0;
  logic [31:0]   reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;
  logic          reg_error;
  logic [N-1:0]  busy = '0;
  logic [N-1:0]  clk_en;
  logic [N-1:0]  rst_out;
  logic [N-1:0]  isolate;
  logic          irq;

  always #5 clk = ~clk;

  chimera_cluster_pwr_ctrl #(
    .NumClusters (N),
    .RstCycles   (RST),
    .TimeoutCyc  (TMO),
    .AddrWidth   (32),
    .DataWidth   (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_valid_i (reg_valid),
    .reg_ready_o (reg_ready),
    .reg_write_i (reg_write),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .busy_i      (busy),
    .clk_en_o    (clk_en),
    .rst_o       (rst_out),
    .isolate_o   (isolate),
    .irq_o       (irq)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase per cluster (0 off, 1 waking, 2 running, 3 draining),
  // cycles left in the current timed phase, and the register file.
  int          m_ph   [N];
  int          m_left [N];
  logic [31:0] m_ctrl, m_pend, m_en, m_tmo;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i]   = 0;
      m_left[i] = 0;
    end
    m_ctrl = '0; m_pend = '0; m_en = '0; m_tmo = '0;
    m_ready = 1'b0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic w,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [N-1:0] b);
    logic [31:0] dn, tm, st_word;
    logic        acc;
    if (r) begin
      model_reset();
      return;
    end
    acc = v && !m_ready;
    st_word = '0;
    for (int i = 0; i < N; i++) st_word = st_word + (m_ph[i] << (2 * i));
    // Register read / error evaluation uses values from before the edge.
    if (acc) begin
      m_err = 1'b0;
      m_rdata = '0;
      if (a == 32'h0) m_rdata = m_ctrl;
      else if (a == 32'h4) begin m_rdata = st_word; m_err = w; end
      else if (a == 32'h8) m_rdata = m_pend;
      else if (a == 32'hC) m_rdata = m_en;
      else if (a == 32'h10 && TMO_EN) m_rdata = m_tmo;
      else m_err = 1'b1;
    end
    // Sequencing per cluster from the targets held before the edge.
    dn = '0; tm = '0;
    for (int i = 0; i < N; i++) begin
      case (m_ph[i])
        0: if (m_ctrl[i]) begin m_ph[i] = 1; m_left[i] = RST; end
        1: begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin m_ph[i] = 2; dn[i] = 1'b1; end
        end
        2: if (!m_ctrl[i]) begin m_ph[i] = 3; m_left[i] = TMO; end
        default: begin
          if (!b[i]) begin
            m_ph[i] = 0; dn[i] = 1'b1;
          end else if (TMO_EN) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin m_ph[i] = 0; dn[i] = 1'b1; tm[i] = 1'b1; end
          end
        end
      endcase
    end
    if (acc && w && !m_err) begin
      if (a == 32'h0) m_ctrl = wd & MASK;
      if (a == 32'h8) m_pend = m_pend & ~(wd & MASK);
      if (a == 32'hC) m_en   = wd & MASK;
      if (a == 32'h10) m_tmo = m_tmo & ~(wd & MASK);
    end
    m_pend  = m_pend | dn;
    m_tmo   = m_tmo | tm;
    m_ready = acc;
  endtask

  // One clock: capture the driven inputs, advance DUT and model, compare.
  task automatic tick();
    logic r, v, w;
    logic [31:0] a, wd;
    logic [N-1:0] b;
    logic [31:0] e_clk, e_rst, e_iso;
    r = rst; v = reg_valid; w = reg_write; a = reg_addr; wd = reg_wdata; b = busy;
    @(posedge clk);
    model_step(r, v, w, a, wd, b);
    #1;
    e_clk = '0; e_rst = '0; e_iso = '0;
    for (int i = 0; i < N; i++) begin
      e_clk[i] = (m_ph[i] != 0);
      e_rst[i] = (m_ph[i] < 2);
      e_iso[i] = (m_ph[i] != 2);
    end
    check("clk_en_o", 32'(clk_en), e_clk);
    check("rst_o", 32'(rst_out), e_rst);
    check("isolate_o", 32'(isolate), e_iso);
    check("irq_o", 32'(irq), 32'(|(m_pend & m_en)));
    check("reg_ready_o", 32'(reg_ready), 32'(m_ready));
    if (m_ready) begin
      check("reg_error_o", 32'(reg_error), 32'(m_err));
      if (!m_err) check("reg_rdata_o", reg_rdata, m_rdata);
    end
  endtask

  task automatic reg_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    reg_valid = 1'b1; reg_write = w; reg_addr = a; reg_wdata = wd;
    tick();
    rd = reg_rdata; er = reg_error;
    reg_valid = 1'b0; reg_write = 1'b0;
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] addr_tab [8];

  initial begin
    addr_tab[0] = 32'h0;  addr_tab[1] = 32'h4;  addr_tab[2] = 32'h8;  addr_tab[3] = 32'hC;
    addr_tab[4] = 32'h10; addr_tab[5] = 32'h14; addr_tab[6] = 32'h2;  addr_tab[7] = 32'h7;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_clk_en", 32'(clk_en), 32'h0);
    check("rst_rst_o", 32'(rst_out), 32'h1F);
    check("rst_iso", 32'(isolate), 32'h1F);
    check("rst_irq", 32'(irq), 32'h0);
    reg_access(1'b0, 32'h4, '0, rd, er);
    check("rst_status", rd, 32'h0);

    // Power up cluster 0
    reg_access(1'b1, 32'hC, 32'h1, rd, er);
    reg_access(1'b1, 32'h0, 32'h1, rd, er);
    check("wake_clk_en0", 32'(clk_en[0]), 32'h1);
    check("wake_rst0", 32'(rst_out[0]), 32'h1);
    repeat (RST - 1) tick();
    check("wake_rst0_held", 32'(rst_out[0]), 32'h1);
    tick();
    check("run_rst0", 32'(rst_out[0]), 32'h0);
    check("run_iso0", 32'(isolate[0]), 32'h0);
    reg_access(1'b0, 32'h4, '0, rd, er);
    check("run_status", rd, 32'h2);
    reg_access(1'b0, 32'h8, '0, rd, er);
    check("run_pend", rd, 32'h1);
    check("run_irq", 32'(irq), 32'h1);

    // Drain cluster 0 while busy
    busy[0] = 1'b1;
    reg_access(1'b1, 32'h0, 32'h0, rd, er);
    reg_access(1'b0, 32'h4, '0, rd, er);
    check("drain_status", rd, 32'h3);
    check("drain_iso0", 32'(isolate[0]), 32'h1);
    repeat (20) tick();
    check("drain_hold_clk0", 32'(clk_en[0]), 32'h1);
    busy[0] = 1'b0;
    tick();
    check("off_clk_en0", 32'(clk_en[0]), 32'h0);
    check("off_rst0", 32'(rst_out[0]), 32'h1);
    reg_access(1'b1, 32'h8, 32'h1F, rd, er);

    // All clusters on, then off while still waking
    reg_access(1'b1, 32'h0, 32'h1F, rd, er);
    reg_access(1'b1, 32'h0, 32'h00, rd, er);
    repeat (15) tick();
    reg_access(1'b0, 32'h8, '0, rd, er);
    check("all_pend", rd, 32'h1F);
    reg_access(1'b0, 32'h4, '0, rd, er);
    check("all_status_off", rd, 32'h0);
    reg_access(1'b1, 32'h8, 32'h1F, rd, er);
    reg_access(1'b0, 32'h8, '0, rd, er);
    check("w1c_pend", rd, 32'h0);

    // Illegal accesses
    reg_access(1'b0, 32'h14, '0, rd, er);
    check("err_rd_14", 32'(er), 32'h1);
    reg_access(1'b1, 32'h4, 32'hFF, rd, er);
    check("err_wr_status", 32'(er), 32'h1);
    reg_access(1'b0, 32'h2, '0, rd, er);
    check("err_misalign", 32'(er), 32'h1);
    reg_access(1'b1, 32'h1, 32'h1F, rd, er);
    check("err_wr_misalign", 32'(er), 32'h1);
    reg_access(1'b0, 32'h0, '0, rd, er);
    check("err_ctrl_unchanged", rd, 32'h0);
    reg_access(1'b0, 32'h10, '0, rd, er);
    check("timeout_reg_err", 32'(er), TMO_EN ? 32'h0 : 32'h1);
    reg_access(1'b1, 32'hC, 32'hFFFF_FFFF, rd, er);
    reg_access(1'b0, 32'hC, '0, rd, er);
    check("en_high_bits", rd, 32'h1F);

    // Target toggled 1->0->1 during wake
    reg_access(1'b1, 32'h0, 32'h1, rd, er);
    reg_access(1'b1, 32'h0, 32'h0, rd, er);
    reg_access(1'b1, 32'h0, 32'h1, rd, er);
    repeat (12) tick();
    reg_access(1'b0, 32'h4, '0, rd, er);
    check("toggle_status", rd, 32'h2);
    reg_access(1'b0, 32'h8, '0, rd, er);
    check("toggle_pend", rd, 32'h1);

    // Reset in the middle of a wake
    reg_access(1'b1, 32'h0, 32'h3, rd, er);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_clk_en", 32'(clk_en), 32'h0);
    check("midrst_rst_o", 32'(rst_out), 32'h1F);
    check("midrst_iso", 32'(isolate), 32'h1F);
    check("midrst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick();
    reg_access(1'b0, 32'h0, '0, rd, er);
    check("midrst_ctrl", rd, 32'h0);

    if (TMO_EN) begin
      // Forced gating of a cluster that never drains
      reg_access(1'b1, 32'h0, 32'h4, rd, er);
      repeat (10) tick();
      busy[2] = 1'b1;
      reg_access(1'b1, 32'h0, 32'h0, rd, er);
      repeat (TMO + 4) tick();
      reg_access(1'b0, 32'h4, '0, rd, er);
      check("tmo_status", rd, 32'h0);
      reg_access(1'b0, 32'h10, '0, rd, er);
      check("tmo_flag", rd, 32'h4);
      busy[2] = 1'b0;
      reg_access(1'b1, 32'h10, 32'h4, rd, er);
    end

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      busy = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        reg_access(1'($urandom), addr_tab[$urandom_range(0, 7)], $urandom, rd, er);
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
